// File: rtl/image_fetch_streamer.sv
// Turns the image memory's fixed one-cycle-latency read port into a raster-ordered valid/ready
// pixel stream with row/column/frame markers. Optional checksum: define IMAGE_FETCH_CHECKSUM_EN.
module image_fetch_streamer #(
  parameter int IMG_W      = 224,
  parameter int IMG_H      = 224,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_pixel,
  input  logic                     mem_valid,
  output logic [DATA_W-1:0]        out_pixel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     out_eof,
  output logic                     err_resp,
  output logic [31:0]              checksum
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state, state_next;
  logic              inflight;
  logic              push, pop, start_accept, credit_ok;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count, fifo_count_next;

  // Every request gets exactly one FIFO slot one cycle later; a missing response becomes a zero pixel.
  assign start_accept    = (state == S_IDLE) && start;
  assign push            = inflight;
  assign push_data       = mem_valid ? mem_pixel : '0;
  assign pop             = out_valid && out_ready;
  assign fifo_count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign credit_ok       = ({1'b0, fifo_count} + (CNT_W + 1)'(inflight)) < DEPTH_EXT;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    mem_req    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: begin
        busy    = 1'b1;
        mem_req = credit_ok;
        if (credit_ok && mem_addr == LAST_ADDR) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!inflight && fifo_count_next == '0) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      inflight <= 1'b0;
      mem_addr <= '0;
      err_resp <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= mem_req;
      if (start_accept)  mem_addr <= '0;
      else if (mem_req)  mem_addr <= mem_addr + ADDR_W'(1);
      err_resp <= err_resp | (inflight & ~mem_valid) | (~inflight & mem_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count_next;
    end
  end

  // NOTE: storage array has no reset; occupancy is tracked by the reset pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  assign out_valid = (fifo_count != '0);
  assign out_pixel = out_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      out_row <= '0;
      out_col <= '0;
    end else if (pop) begin
      if (out_col == LAST_COL) begin
        out_col <= '0;
        out_row <= (out_row == LAST_ROW) ? '0 : out_row + ROW_W'(1);
      end else begin
        out_col <= out_col + COL_W'(1);
      end
    end
  end

  assign out_sof = out_valid && (out_row == '0) && (out_col == '0);
  assign out_eol = out_valid && (out_col == LAST_COL);
  assign out_eof = out_eol && (out_row == LAST_ROW);

`ifdef IMAGE_FETCH_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge clk) begin
    if (rst || start_accept) csum <= '0;
    else if (pop)            csum <= csum + 32'(out_pixel);
  end

  assign checksum = csum;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_image_fetch_streamer.sv
// Self-checking bench for image_fetch_streamer: a one-cycle memory responder plus a
// frame-level reference model (pixel index -> row/col/flags, FIFO occupancy, credit limit).
`timescale 1ns/1ps
module tb_image_fetch_streamer;
  localparam int IMG_W = 24;
  localparam int IMG_H = 10;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH = 4;
  localparam int N = IMG_W * IMG_H;

`ifdef IMAGE_FETCH_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, busy, done, mem_req, mem_valid, out_valid, out_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_pixel, out_pixel;
  logic [$clog2(IMG_H)-1:0] out_row;
  logic [$clog2(IMG_W)-1:0] out_col;
  logic out_sof, out_eol, out_eof, err_resp;
  logic [31:0] checksum;

  logic [DATA_W-1:0] img [N];
  int drop_addr = -1;
  bit inject = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  image_fetch_streamer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_pixel(mem_pixel), .mem_valid(mem_valid),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_sof(out_sof), .out_eol(out_eol),
    .out_eof(out_eof), .err_resp(err_resp), .checksum(checksum)
  );

  // Memory: answers a request seen in one cycle during the next cycle, optionally dropping one address.
  initial begin : responder
    logic r;
    logic [ADDR_W-1:0] a;
    mem_valid = 1'b0;
    mem_pixel = '0;
    forever begin
      @(negedge clk);
      r = mem_req;
      a = mem_addr;
      @(posedge clk);
      #1;
      mem_valid = (r && !(drop_addr >= 0 && int'(a) == drop_addr)) || inject;
      mem_pixel = (r && int'(a) < N) ? img[a] : 16'hdead;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle();
    repeat (4) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_req", mem_req, 0);
      check("idle_addr", mem_addr, 0);
      check("idle_valid", out_valid, 0);
      check("idle_pixel", out_pixel, 0);
      check("idle_row", out_row, 0);
      check("idle_col", out_col, 0);
      check("idle_flags", {out_sof, out_eol, out_eof}, 0);
      check("idle_err", err_resp, 0);
      check("idle_checksum", checksum, 0);
    end
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from a start pulse; called and returns at posedge+1.
  task automatic run_frame(input int mode, input int stall_at, input int restart_at,
                           input int drop_a, input int abort_at, input bit err0);
    logic [DATA_W-1:0] exp_q [N];
    int idx, issued, occ, stall_left, addr1;
    bit req1, req2, hs1, hs, err_m, exp_req, exp_val, finished, aborted, restarted;
    logic [31:0] sum;
    for (int i = 0; i < N; i++) exp_q[i] = (i == drop_a) ? '0 : img[i];
    idx = 0; issued = 0; occ = 0; stall_left = 20; addr1 = -1;
    req1 = 0; req2 = 0; hs1 = 0; finished = 0; aborted = 0; restarted = 0;
    sum = '0;
    err_m = err0;
    drop_addr = drop_a;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 20 * N && !finished; cyc++) begin
      @(negedge clk);
      occ = occ + int'(req2) - int'(hs1);
      exp_val = occ > 0;
      exp_req = (issued < N) && (occ + int'(req1) < DEPTH);
      check("busy", busy, idx < N);
      check("done", done, idx == N);
      check("out_valid", out_valid, exp_val);
      check("mem_req", mem_req, exp_req);
      if (exp_req) check("mem_addr", mem_addr, issued);
      check("err_resp", err_resp, err_m);
      check("checksum", checksum, CK_EN ? sum : 32'd0);
      if (exp_val) begin
        check("pixel", out_pixel, exp_q[idx]);
        check("row", out_row, idx / IMG_W);
        check("col", out_col, idx % IMG_W);
        check("sof", out_sof, idx == 0);
        check("eol", out_eol, (idx % IMG_W) == IMG_W - 1);
        check("eof", out_eof, idx == N - 1);
      end
      if (idx == N) finished = 1;
      hs = exp_val && out_ready;
      if (hs) begin
        sum = sum + 32'(exp_q[idx]);
        idx++;
      end
      if (req1 && addr1 == drop_a) err_m = 1'b1;
      req2 = req1;
      req1 = exp_req;
      addr1 = exp_req ? issued : -1;
      hs1 = hs;
      if (exp_req) issued++;
      if (!finished && abort_at >= 0 && idx == abort_at) begin
        aborted = 1;
        break;
      end
      @(posedge clk);
      #1;
      if (stall_at >= 0 && idx >= stall_at && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      start = (restart_at >= 0 && idx >= restart_at && !restarted);
      if (start) restarted = 1;
    end
    check("frame_end", finished || aborted, 1);
    if (aborted) begin
      @(posedge clk);
      #1;
      do_reset();
      check_idle();
    end else begin
      @(negedge clk);
      check("done_pulse_end", done, 0);
      check("busy_after", busy, 0);
      check("checksum_hold", checksum, CK_EN ? sum : 32'd0);
      check("valid_after", out_valid, 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    do_reset();
    check_idle();

    // addr-valued pixels, full throughput
    for (int i = 0; i < N; i++) img[i] = 16'(i);
    run_frame(0, -1, -1, -1, -1, 1'b0);

    // random pixels, random back-pressure, stray start while busy
    for (int i = 0; i < N; i++) img[i] = 16'($urandom);
    run_frame(1, -1, 50, -1, -1, 1'b0);

    // 20-cycle stall mid-row
    for (int i = 0; i < N; i++) img[i] = 16'($urandom);
    run_frame(0, 30, -1, -1, -1, 1'b0);

    // missing response at address 100, then error must stay sticky for the next frame
    for (int i = 0; i < N; i++) img[i] = 16'(i);
    run_frame(0, -1, -1, 100, -1, 1'b0);
    for (int i = 0; i < N; i++) img[i] = 16'($urandom);
    run_frame(1, -1, -1, -1, -1, 1'b1);

    // reset clears the error; abort a frame at pixel 100 and restart cleanly
    do_reset();
    check_idle();
    run_frame(1, -1, -1, -1, 100, 1'b0);
    for (int i = 0; i < N; i++) img[i] = 16'h0001;
    run_frame(0, -1, -1, -1, -1, 1'b0);

    // unsolicited response while idle
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    check("unsol_err_before", err_resp, 0);
    @(negedge clk);
    check("unsol_err_after", err_resp, 1);
    check("unsol_dropped", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
